// File: rtl/alu_issue_if.sv
// Bundle of the instruction handshake, ALU operand/result, writeback and debug-read
// signals between the instruction producer/ALU environment and the alu_issue stage.
interface alu_issue_if #(
   parameter int DW = 64
) ();
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   in_instr;
   logic [5:0]    alu_instr;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [DW-1:0] alu_out;
   logic          wb_valid;
   logic [4:0]    wb_addr;
   logic [DW-1:0] wb_data;
   logic          err;
   logic [4:0]    dbg_addr;
   logic [DW-1:0] dbg_data;

   modport master (
      output in_valid, in_instr, alu_out, dbg_addr,
      input  in_ready, alu_instr, alu_a, alu_b, wb_valid, wb_addr, wb_data, err, dbg_data
   );

   modport slave (
      input  in_valid, in_instr, alu_out, dbg_addr,
      output in_ready, alu_instr, alu_a, alu_b, wb_valid, wb_addr, wb_data, err, dbg_data
   );
endinterface

// File: rtl/alu_issue.sv
// Decode/issue stage: decodes MIPS R/I arithmetic instructions, reads a 32-entry register
// file, drives the ALU, waits ALU_LAT edges and writes the ALU result back.
module alu_issue #(
   parameter int DW      = 64,
   parameter int ALU_LAT = 1
) (
   input  logic       c,
   input  logic       rst,
   alu_issue_if.slave bus
);
   localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

   typedef enum logic {ST_IDLE, ST_EXEC} state_t;

   state_t         r_state;
   state_t         w_state_next;
   logic [CW-1:0]  r_cnt;
   logic [CW-1:0]  w_cnt_next;
   logic           w_wb_fire;

   logic [DW-1:0]  r_rf [32];
   logic [5:0]     r_alu_instr;
   logic [DW-1:0]  r_alu_a;
   logic [DW-1:0]  r_alu_b;
   logic [4:0]     r_dest;
   logic           r_wb_valid;
   logic [4:0]     r_wb_addr;
   logic [DW-1:0]  r_wb_data;
   logic           r_err;

   logic [5:0]     w_op;
   logic [4:0]     w_rs;
   logic [4:0]     w_rt;
   logic [4:0]     w_rd;
   logic [4:0]     w_shamt;
   logic [5:0]     w_funct;
   logic [15:0]    w_imm;
   logic [DW-1:0]  w_rs_val;
   logic [DW-1:0]  w_rt_val;
   logic           w_legal;
   logic [5:0]     w_code;
   logic [DW-1:0]  w_a;
   logic [DW-1:0]  w_b;
   logic [4:0]     w_dest;
   logic           w_accept;

   assign w_op    = bus.in_instr[31:26];
   assign w_rs    = bus.in_instr[25:21];
   assign w_rt    = bus.in_instr[20:16];
   assign w_rd    = bus.in_instr[15:11];
   assign w_shamt = bus.in_instr[10:6];
   assign w_funct = bus.in_instr[5:0];
   assign w_imm   = bus.in_instr[15:0];

   // Entry 0 is held at zero forever, so no special read path is needed for R0.
   assign w_rs_val = r_rf[w_rs];
   assign w_rt_val = r_rf[w_rt];

   assign w_accept = bus.in_valid && (r_state == ST_IDLE);

   always_comb begin
      w_legal = 1'b0;
      w_code  = w_op;
      w_a     = w_rs_val;
      w_b     = '0;
      w_dest  = w_rt;
      if (w_op == 6'b000000) begin
         w_code = w_funct;
         w_dest = w_rd;
         case (w_funct)
            6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b011000, 6'b011001, 6'b011010, 6'b011011: begin
               w_legal = 1'b1;
               w_b     = w_rt_val;
            end
            6'b000000, 6'b000010, 6'b000011: begin
               w_legal = 1'b1;
               w_a     = w_rt_val;
               w_b     = DW'(w_shamt);
            end
            6'b000100, 6'b000110, 6'b000111: begin
               w_legal = 1'b1;
               w_a     = w_rt_val;
               w_b     = w_rs_val;
            end
            default: w_legal = 1'b0;
         endcase
      end else begin
         case (w_op)
            6'b001000, 6'b001001: begin
               w_legal = 1'b1;
               w_b     = {{(DW-16){w_imm[15]}}, w_imm};
            end
            6'b001100, 6'b001101, 6'b001110: begin
               w_legal = 1'b1;
               w_b     = {{(DW-16){1'b0}}, w_imm};
            end
            default: w_legal = 1'b0;
         endcase
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_wb_fire    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept && w_legal) begin
               w_state_next = ST_EXEC;
               w_cnt_next   = '0;
            end
         end
         ST_EXEC: begin
            if (r_cnt == CW'(ALU_LAT)) begin
               w_wb_fire    = 1'b1;
               w_state_next = ST_IDLE;
               w_cnt_next   = '0;
            end else begin
               w_cnt_next = r_cnt + CW'(1);
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge c) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
      end
   end

   always_ff @(posedge c) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            r_rf[i] <= '0;
         end
      end else if (w_wb_fire && (r_dest != 5'd0)) begin
         r_rf[r_dest] <= bus.alu_out;
      end
   end

   // ALU operands are captured only on a legal accept and held until the next one.
   always_ff @(posedge c) begin
      if (rst) begin
         r_alu_instr <= '0;
         r_alu_a     <= '0;
         r_alu_b     <= '0;
         r_dest      <= '0;
      end else if (w_accept && w_legal) begin
         r_alu_instr <= w_code;
         r_alu_a     <= w_a;
         r_alu_b     <= w_b;
         r_dest      <= w_dest;
      end
   end

   always_ff @(posedge c) begin
      if (rst) begin
         r_wb_valid <= 1'b0;
         r_wb_addr  <= '0;
         r_wb_data  <= '0;
         r_err      <= 1'b0;
      end else begin
         r_wb_valid <= w_wb_fire;
         r_err      <= w_accept && !w_legal;
         if (w_wb_fire) begin
            r_wb_addr <= r_dest;
            r_wb_data <= bus.alu_out;
         end
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.alu_instr = r_alu_instr;
   assign bus.alu_a     = r_alu_a;
   assign bus.alu_b     = r_alu_b;
   assign bus.wb_valid  = r_wb_valid;
   assign bus.wb_addr   = r_wb_addr;
   assign bus.wb_data   = r_wb_data;
   assign bus.err       = r_err;
   assign bus.dbg_data  = r_rf[bus.dbg_addr];
endmodule

// File: tb/tb_alu_issue.sv
// Directed plus randomized bench for alu_issue with a simple registered ALU model and an
// instruction-level reference model of decode and register file.
module tb_alu_issue;
   localparam int DW      = 64;
   localparam int ALU_LAT = 1;

   logic c   = 1'b0;
   logic rst = 1'b1;

   alu_issue_if #(.DW(DW)) bus ();

   alu_issue #(.DW(DW), .ALU_LAT(ALU_LAT)) dut (
      .c   (c),
      .rst (rst),
      .bus (bus)
   );

   always #5 c = ~c;

   int errors = 0;
   int checks = 0;
   int last_waits = 0;

   logic [63:0] m_rf [32];
   logic [5:0]  m_alu_instr;
   logic [63:0] m_alu_a;
   logic [63:0] m_alu_b;

   typedef struct {
      bit          legal;
      logic [5:0]  code;
      logic [63:0] a;
      logic [63:0] b;
      logic [4:0]  dest;
   } dec_t;

   function automatic logic [63:0] alu_fn(input logic [5:0] op, input logic [63:0] a,
                                          input logic [63:0] b);
      case (op)
         6'b100000, 6'b100001, 6'b001000, 6'b001001: return a + b;
         6'b100010, 6'b100011:                       return a - b;
         6'b100100, 6'b001100:                       return a & b;
         6'b100101, 6'b001101:                       return a | b;
         6'b100110, 6'b001110:                       return a ^ b;
         6'b100111:                                  return ~(a | b);
         6'b011000, 6'b011001:                       return a * b;
         6'b011010, 6'b011011:                       return (b == 0) ? 64'd0 : a / b;
         6'b000000, 6'b000100:                       return a << b[5:0];
         6'b000010, 6'b000110:                       return a >> b[5:0];
         6'b000011, 6'b000111:                       return $signed(a) >>> b[5:0];
         default:                                    return 64'd0;
      endcase
   endfunction

   // One-edge ALU: inputs sampled at an edge, result visible until the following edge.
   always @(posedge c) bus.alu_out <= alu_fn(bus.alu_instr, bus.alu_a, bus.alu_b);

   function automatic dec_t ref_decode(input logic [31:0] ins);
      dec_t        d;
      logic [5:0]  op    = ins[31:26];
      logic [5:0]  fn    = ins[5:0];
      logic [63:0] ra    = m_rf[ins[25:21]];
      logic [63:0] rtv   = m_rf[ins[20:16]];
      logic [15:0] imm   = ins[15:0];
      d.legal = 0; d.code = op; d.a = ra; d.b = 0; d.dest = ins[20:16];
      if (op == 6'd0) begin
         d.code = fn;
         d.dest = ins[15:11];
         if (fn inside {6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                        6'h18, 6'h19, 6'h1a, 6'h1b}) begin
            d.legal = 1; d.b = rtv;
         end else if (fn inside {6'h00, 6'h02, 6'h03}) begin
            d.legal = 1; d.a = rtv; d.b = 64'(ins[10:6]);
         end else if (fn inside {6'h04, 6'h06, 6'h07}) begin
            d.legal = 1; d.a = rtv; d.b = ra;
         end
      end else if (op inside {6'h08, 6'h09}) begin
         d.legal = 1; d.b = 64'($signed(imm));
      end else if (op inside {6'h0c, 6'h0d, 6'h0e}) begin
         d.legal = 1; d.b = {48'd0, imm};
      end
      return d;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Offers one instruction, follows it to writeback (or err) and checks every output.
   task automatic issue(input logic [31:0] ins);
      dec_t        d = ref_decode(ins);
      int          waits = 0;
      logic [63:0] res;
      logic [4:0]  pa;
      bus.in_instr = ins;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && waits < 20) begin
         @(posedge c); #1;
         waits++;
      end
      last_waits = waits;
      if (!bus.in_ready) begin
         chk("accept_timeout", 64'(bus.in_ready), 64'd1);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge c); #1;
      bus.in_valid = 1'b0;
      $display("txn instr=%08h legal=%0d code=%02h dest=%0d waits=%0d",
               ins, d.legal, d.code, d.dest, waits);
      if (d.legal) begin
         chk("alu_instr", 64'(bus.alu_instr), 64'(d.code));
         chk("alu_a", bus.alu_a, d.a);
         chk("alu_b", bus.alu_b, d.b);
         chk("exec_ready", 64'(bus.in_ready), 64'd0);
         chk("exec_err", 64'(bus.err), 64'd0);
         chk("wb_early", 64'(bus.wb_valid), 64'd0);
         m_alu_instr = d.code; m_alu_a = d.a; m_alu_b = d.b;
         for (int i = 0; i < ALU_LAT; i++) begin
            @(posedge c); #1;
            chk("wb_wait", 64'(bus.wb_valid), 64'd0);
         end
         @(posedge c); #1;
         res = alu_fn(d.code, d.a, d.b);
         chk("wb_valid", 64'(bus.wb_valid), 64'd1);
         chk("wb_addr", 64'(bus.wb_addr), 64'(d.dest));
         chk("wb_data", bus.wb_data, res);
         chk("wb_ready", 64'(bus.in_ready), 64'd1);
         if (d.dest != 5'd0) m_rf[d.dest] = res;
         bus.dbg_addr = d.dest;
         #1;
         chk("dbg_dest", bus.dbg_data, m_rf[d.dest]);
      end else begin
         chk("err_pulse", 64'(bus.err), 64'd1);
         chk("err_ready", 64'(bus.in_ready), 64'd1);
         chk("err_no_wb", 64'(bus.wb_valid), 64'd0);
         chk("err_alu_instr", 64'(bus.alu_instr), 64'(m_alu_instr));
         chk("err_alu_a", bus.alu_a, m_alu_a);
         chk("err_alu_b", bus.alu_b, m_alu_b);
         pa = 5'($urandom_range(0, 31));
         bus.dbg_addr = pa;
         #1;
         chk("err_rf_keep", bus.dbg_data, m_rf[pa]);
      end
   endtask

   logic [5:0] arith_f [12] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                                6'h18, 6'h19, 6'h1a, 6'h1b};
   logic [5:0] shimm_f [3]  = '{6'h00, 6'h02, 6'h03};
   logic [5:0] shvar_f [3]  = '{6'h04, 6'h06, 6'h07};
   logic [5:0] iop     [5]  = '{6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e};
   logic [5:0] bad_op  [4]  = '{6'h23, 6'h2b, 6'h04, 6'h0f};
   logic [5:0] bad_fn  [3]  = '{6'h08, 6'h10, 6'h2a};

   initial begin
      logic [31:0] ins;
      int          kind;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_alu_instr = '0; m_alu_a = '0; m_alu_b = '0;
      bus.in_valid = 1'b0;
      bus.in_instr = '0;
      bus.dbg_addr = '0;

      repeat (2) @(posedge c);
      #1 rst = 1'b0;
      chk("rst_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_alu_instr", 64'(bus.alu_instr), 64'd0);
      chk("rst_alu_a", bus.alu_a, 64'd0);
      chk("rst_alu_b", bus.alu_b, 64'd0);
      chk("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
      chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
      chk("rst_wb_data", bus.wb_data, 64'd0);
      chk("rst_err", 64'(bus.err), 64'd0);
      for (int i = 0; i < 32; i++) begin
         bus.dbg_addr = 5'(i);
         #0.1;
         chk("rst_dbg", bus.dbg_data, 64'd0);
      end

      issue(32'h340100FF);                       // ori r1,r0,0xFF
      issue(32'h2002FFFF);                       // addi r2,r0,-1
      issue(32'h00221820);                       // add r3,r1,r2 at earliest accept
      chk("raw_no_stall", 64'(last_waits), 64'd0);
      issue(32'h00012100);                       // sll r4,r1,4
      issue(32'h00812804);                       // sllv r5,r1,r4
      issue(32'h8C010000);                       // lw: unsupported
      issue(32'h8C220000);                       // second unsupported, back to back
      issue(32'h00210020);                       // add r0,r1,r1
      bus.dbg_addr = 5'd0;
      #1 chk("r0_zero", bus.dbg_data, 64'd0);

      // Reset one cycle into EXEC abandons the instruction.
      bus.in_instr = 32'h34060005;
      bus.in_valid = 1'b1;
      @(posedge c); #1;
      bus.in_valid = 1'b0;
      rst = 1'b1;
      @(posedge c); #1;
      rst = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_alu_instr = '0; m_alu_a = '0; m_alu_b = '0;
      chk("abort_no_wb", 64'(bus.wb_valid), 64'd0);
      chk("abort_ready", 64'(bus.in_ready), 64'd1);
      chk("abort_alu_a", bus.alu_a, 64'd0);
      @(posedge c); #1;
      chk("abort_no_wb2", 64'(bus.wb_valid), 64'd0);
      bus.dbg_addr = 5'd6;
      #1 chk("abort_r6", bus.dbg_data, 64'd0);
      bus.dbg_addr = 5'd1;
      #1 chk("abort_r1", bus.dbg_data, 64'd0);

      for (int n = 0; n < 60; n++) begin
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            if ($urandom_range(0, 1) == 0)
               ins = {bad_op[$urandom_range(0, 3)], 26'($urandom)};
            else
               ins = {6'd0, 20'($urandom), bad_fn[$urandom_range(0, 2)]};
         end else if (kind <= 4) begin
            ins = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'd0, arith_f[$urandom_range(0, 11)]};
         end else if (kind == 5) begin
            ins = {6'd0, 5'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom), shimm_f[$urandom_range(0, 2)]};
         end else if (kind == 6) begin
            ins = {6'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'd0, shvar_f[$urandom_range(0, 2)]};
         end else begin
            ins = {iop[$urandom_range(0, 4)], 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 16'($urandom)};
         end
         repeat ($urandom_range(0, 2)) begin
            @(posedge c); #1;
         end
         issue(ins);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
